// File: rtl/led_pkg.sv
// Shared encodings for the LED controller: per-LED modes and command FSM states.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PCNT_W = 4;

endpackage

// File: rtl/led_tick.sv
// Blink timebase: prescaler wrapping every TICK_DIV cycles, 1-cycle tick strobe
// on the wrap cycle, and a shared phase bit that toggles on each tick.
module led_tick #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic phase
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign phase = phase_q;

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    phase_d = tick ? ~phase_q : phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// LED controller: 3-state command FSM writing per-LED modes, registered active-low drive.
// Define LED_CTRL_BLINK_EN to build the blink/pulse timebase; otherwise BLINK and PULSE act as ON.
module led_ctrl
  import led_pkg::*;
#(
  parameter int N_LED       = 32,
  parameter int TICK_DIV    = 25_000_000,
  parameter int PULSE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_idx,
  input  logic [1:0]       cmd_mode,
  output logic [N_LED-1:0] led
);

  if (N_LED < 1 || N_LED > 32 || TICK_DIV < 2 || PULSE_TICKS < 1 || PULSE_TICKS > 15)
  begin : g_bad_param
    $error("led_ctrl: parameter out of range");
  end

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [4:0]       idx_q, idx_d;
  mode_e            cap_q, cap_d;
  mode_e            mode_q [N_LED];
  mode_e            mode_d [N_LED];
  logic [N_LED-1:0] led_q, led_d;

`ifdef LED_CTRL_BLINK_EN
  logic              tick, phase;
  logic [PCNT_W-1:0] pcnt_q [N_LED];
  logic [PCNT_W-1:0] pcnt_d [N_LED];

  led_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .phase (phase)
  );
`endif

  assign cmd_ready = ready_q;
  assign led       = led_q;

  // Ready is registered so it stays low through reset and rises one edge after release.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = ST_APPLY;
          idx_d   = cmd_idx;
          cap_d   = mode_e'(cmd_mode);
        end
      end
      ST_APPLY: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_comb begin
    led_d = led_q;
    for (int i = 0; i < N_LED; i++) begin
      mode_d[i] = mode_q[i];
`ifdef LED_CTRL_BLINK_EN
      pcnt_d[i] = pcnt_q[i];
      if (tick && pcnt_q[i] != '0) begin
        pcnt_d[i] = pcnt_q[i] - PCNT_W'(1);
        if (pcnt_q[i] == PCNT_W'(1)) mode_d[i] = MODE_OFF;
      end
`endif
      // The command write comes last so it overrides a same-cycle tick or expiry.
      if (state_q == ST_APPLY && int'(idx_q) == i) begin
        mode_d[i] = cap_q;
`ifdef LED_CTRL_BLINK_EN
        pcnt_d[i] = (cap_q == MODE_PULSE) ? PCNT_W'(PULSE_TICKS) : '0;
`endif
      end
      case (mode_q[i])
        MODE_OFF: led_d[i] = 1'b1;
        MODE_ON:  led_d[i] = 1'b0;
`ifdef LED_CTRL_BLINK_EN
        MODE_BLINK: led_d[i] = ~phase;
        MODE_PULSE: led_d[i] = (pcnt_q[i] == '0);
`else
        MODE_BLINK: led_d[i] = 1'b0;
        MODE_PULSE: led_d[i] = 1'b0;
`endif
        default: led_d[i] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      idx_q   <= '0;
      cap_q   <= MODE_OFF;
      led_q   <= '1;
      for (int i = 0; i < N_LED; i++) begin
        mode_q[i] <= MODE_OFF;
`ifdef LED_CTRL_BLINK_EN
        pcnt_q[i] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      led_q   <= led_d;
      for (int i = 0; i < N_LED; i++) begin
        mode_q[i] <= mode_d[i];
`ifdef LED_CTRL_BLINK_EN
        pcnt_q[i] <= pcnt_d[i];
`endif
      end
    end
  end

endmodule
